// File: rtl/cipher_pkg.sv
// Shared constants, key-word type and sizing helper for the keystream XOR cipher.
package cipher_pkg;

    localparam int unsigned CIPHER_DATA_W    = 8;
    localparam int unsigned CIPHER_KEY_DEPTH = 4;

    typedef logic [CIPHER_DATA_W-1:0] key_word_t;

    // Ceiling log2 usable in parameter expressions; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        if (v > 1) begin
            x = v - 1;
            while (x > 0) begin
                r = r + 1;
                x = x >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/keystream_xor_cipher_key_word_fifo.sv
// Synchronous key-word FIFO with async reset and synchronous clear.
// Clear wins over push/pop; push when full and pop when empty are ignored.
module key_word_fifo
    import cipher_pkg::*;
#(
    parameter  int unsigned DATA_W = CIPHER_DATA_W,
    parameter  int unsigned DEPTH  = CIPHER_KEY_DEPTH,
    localparam int unsigned AW     = clog2(DEPTH),
    localparam int unsigned LW     = AW + 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic [LW-1:0]     o_level
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == LW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_level = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full  & ~i_clear;
    assign w_pop  = i_pop  & ~o_empty & ~i_clear;

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/keystream_xor_cipher.sv
// Packs LFSR keystream bits LSB-first into key words, buffers them, and XORs
// one key word onto each accepted data word behind a registered output stage.
module keystream_xor_cipher
    import cipher_pkg::*;
#(
    parameter  int unsigned DATA_W    = CIPHER_DATA_W,
    parameter  int unsigned KEY_DEPTH = CIPHER_KEY_DEPTH,
    localparam int unsigned LW        = clog2(KEY_DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_sync_clear,
    input  logic              i_ks_bit,
    input  logic              i_ks_valid,
    output logic              o_ks_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    input  logic              i_out_ready,
    output logic [LW-1:0]     o_key_level
);

    localparam int unsigned CW = clog2(DATA_W);

    logic [DATA_W-1:0] r_acc;
    logic [CW-1:0]     r_bit_cnt;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_key_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [LW-1:0]     w_level;
    logic              w_ks_fire;
    logic              w_d_fire;
    logic              w_word_done;

    // Both readies depend only on registered state, never on i_data_valid.
    assign o_ks_ready   = ~w_fifo_full;
    assign o_data_ready = ~w_fifo_empty & (~o_data_valid | i_out_ready);
    assign o_key_level  = w_level;

    // A sync clear discards any handshake that coincides with it.
    assign w_ks_fire   = i_ks_valid & o_ks_ready & ~i_sync_clear;
    assign w_d_fire    = i_data_valid & o_data_ready & ~i_sync_clear;
    assign w_word_done = w_ks_fire & (r_bit_cnt == CW'(DATA_W - 1));
    assign w_word      = {i_ks_bit, r_acc[DATA_W-1:1]};

    key_word_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (KEY_DEPTH)
    ) u_key_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (i_sync_clear),
        .i_push      (w_word_done),
        .i_push_data (w_word),
        .i_pop       (w_d_fire),
        .o_head      (w_key_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_level     (w_level)
    );

    // Shift register: the first accepted bit ends up in word bit 0.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_acc     <= '0;
            r_bit_cnt <= '0;
        end else if (i_sync_clear) begin
            r_acc     <= '0;
            r_bit_cnt <= '0;
        end else if (w_ks_fire) begin
            r_acc     <= w_word;
            r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + CW'(1);
        end
    end

    // Output register: load on accept, drop valid once consumed, hold while stalled.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_data       <= '0;
            o_data_valid <= 1'b0;
        end else if (i_sync_clear) begin
            o_data_valid <= 1'b0;
        end else if (w_d_fire) begin
            o_data       <= i_data ^ w_key_head;
            o_data_valid <= 1'b1;
        end else if (o_data_valid & i_out_ready) begin
            o_data_valid <= 1'b0;
        end
    end

endmodule

// File: doc/keystream_xor_cipher.md
Name: keystream_xor_cipher

Overview:
Downstream consumer of the 1-bit-per-cycle LFSR keystream. Packs accepted keystream bits LSB-first into DATA_W-bit key words and buffers them in a small key FIFO. Each key word is XORed with one plaintext/ciphertext word arriving on a valid/ready interface. Results are presented on a registered valid/ready output. o_ks_ready is the clock-enable for the LFSR stage, so no keystream bit is ever lost.

Parameters:
DATA_W, 8, width of data and key words (>=2)
KEY_DEPTH, 4, key FIFO depth in words (power of 2, >=2)

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_sync_clear  in  1  synchronous flush of key path and output stage (used when the LFSR is reseeded)
i_ks_bit  in  1  keystream bit from LFSR
i_ks_valid  in  1  keystream bit valid
o_ks_ready  out  1  block can accept a keystream bit; drives LFSR enable
i_data  in  DATA_W  input word
i_data_valid  in  1  input word valid
o_data_ready  out  1  input word accepted this cycle if valid
o_data  out  DATA_W  i_data XOR key word
o_data_valid  out  1  output valid
i_out_ready  in  1  downstream ready
o_key_level  out  clog2(KEY_DEPTH)+1  number of complete key words buffered

Behaviour:
- Reset (async, i_reset=1) state: accumulator, bit counter, FIFO pointers and count = 0; o_data=0, o_data_valid=0, o_key_level=0. Because the FIFO is empty, o_ks_ready=1 and o_data_ready=0 during reset.
- Keystream acceptance: ks_fire = i_ks_valid & o_ks_ready. o_ks_ready = (key_level != KEY_DEPTH). It is derived from registered state only, so there is no combinational path from i_data_valid or i_out_ready.
- Accumulator: on ks_fire, acc <= {i_ks_bit, acc[DATA_W-1:1]} and bit_cnt increments. The first accepted bit lands in word bit 0.
- Word completion: when ks_fire and bit_cnt==DATA_W-1, push {i_ks_bit, acc[DATA_W-1:1]} into the FIFO in the same cycle and set bit_cnt to 0. o_key_level reflects the push on the next cycle.
- No push can occur when the FIFO is full, because o_ks_ready is low.
- Data transfer:
  - o_data_ready = (key_level != 0) & (!o_data_valid | i_out_ready).
  - d_fire = i_data_valid & o_data_ready.
  - On d_fire: o_data <= i_data ^ fifo_head, o_data_valid <= 1, pop the FIFO.
  - Latency is 1 cycle. Throughput is 1 word per cycle while keys are available.
- Output stage: if o_data_valid & i_out_ready & !d_fire, then o_data_valid <= 0. While o_data_valid & !i_out_ready, o_data is held stable.
- Simultaneous push and pop: allowed when the FIFO is not full. key_level is unchanged and both pointers advance, wrapping modulo KEY_DEPTH.
- i_sync_clear takes precedence over every event in its cycle:
  - acc, bit_cnt, FIFO pointers and count go to 0; o_data_valid goes to 0.
  - A ks_fire or d_fire in the same cycle is discarded.
  - o_data is not required to change.
- Reset mid-operation: all state returns to reset values immediately. A partial key word is discarded.

Decomposition:
- Shared package cipher_pkg:
  - constants CIPHER_DATA_W=8 and CIPHER_KEY_DEPTH=4;
  - function clog2;
  - typedef of the key word, DATA_W bits.
- One sub-module: key_word_fifo. It is a synchronous FIFO with push/pop/full/empty/level, async reset and sync clear. The top level holds the accumulator, handshake logic and output register.

Test Plan:
1. After reset, feed bits 1,0,1,1,0,0,1,0 on consecutive cycles -> o_key_level=1 one cycle after the 8th bit. Then present i_data=0xFF with i_out_ready=1 -> next cycle o_data=0xB2 (key 0x4D), o_data_valid=1, and o_key_level returns to 0.
2. i_data_valid=1 held with o_key_level=0 -> o_data_ready=0 and o_data_valid stays 0. Complete one key word (all 1s, key 0xFF) -> accepts i_data=0x3C, output 0xC3.
3. Feed 40 consecutive 1-bits with no data traffic -> o_key_level=4 and o_ks_ready=0 from the cycle after the 32nd bit. Bits 33-40 are not accepted and bit_cnt stays 0. Pop one word -> o_ks_ready returns to 1.
4. Output valid with i_out_ready=0 for 5 cycles -> o_data held stable and o_data_ready=0. Raise i_out_ready together with a new input -> the new word replaces the old one with no bubble and no loss.
5. Preload 4 keys (0x01, 0x02, 0x04, 0x08), then stream data 0x00 continuously with i_out_ready=1 -> outputs 0x01, 0x02, 0x04, 0x08 on 4 consecutive cycles. Keystream pushes during the pops keep the level consistent.
6. Load 2 keys plus 5 bits, pulse i_sync_clear -> level 0 and o_data_valid 0; the next 8 bits form a fresh word. Separately, assert i_reset in the middle of a transfer -> all outputs go to reset values without waiting for a clock edge.
